// File: rtl/pool_pkg.sv
// Shared definitions for the forward max-pooling reducer.
// Holds float/index widths, the NaN exponent pattern, the FSM state type
// and the NaN classifier used by both the comparator and the top level.
package pool_pkg;

   localparam int unsigned FLT_W = 32;
   localparam int unsigned IDX_W = 8;
   localparam logic [7:0]  FLT_EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } pool_fwd_state_t;

   // NaN: all-ones exponent with a non-zero mantissa (infinities excluded)
   function automatic logic is_nan(input logic [FLT_W-1:0] v);
      return (v[30:23] == FLT_EXP_MAX) && (v[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/float_gt_cmp.sv
// Combinational single-precision "a strictly greater than b" on raw bits.
// Ports:
//   a, b : FLT_W-bit IEEE-754 operands
//   gt   : 1 when a > b; -0 and +0 are equal; any NaN operand gives 0
module float_gt_cmp
   import pool_pkg::*;
(
   input  logic [FLT_W-1:0] a,
   input  logic [FLT_W-1:0] b,
   output logic             gt
);

   logic a_zero;
   logic b_zero;

   assign a_zero = (a[30:0] == 31'd0);
   assign b_zero = (b[30:0] == 31'd0);

   always_comb begin
      gt = 1'b0;
      if (is_nan(a) || is_nan(b)) begin
         gt = 1'b0;
      end else if (a_zero && b_zero) begin
         gt = 1'b0;                       // signed zeros tie
      end else if (a[31] != b[31]) begin
         gt = ~a[31];                     // positive beats negative
      end else if (!a[31]) begin
         gt = (a[30:0] > b[30:0]);
      end else begin
         gt = (a[30:0] < b[30:0]);        // both negative: smaller magnitude wins
      end
   end

endmodule

// File: rtl/pooling_forward_max.sv
// Forward max-pooling reducer for one kernel window.
// Captures a K_SIZE vector of single-precision values, scans it one element
// per cycle, and returns the maximum plus its index for the backward pass.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   in_valid / in_ready     : window handshake (in_ready only in IDLE)
//   data_vect_in            : K_SIZE x FLT_W window values
//   out_valid / out_ready   : result handshake
//   max_flt, max_flt_idx    : result value and its index
//   nan_flag                : window held a NaN (only with POOL_FWD_NAN_FLAG_EN,
//                             otherwise constant 0)
module pooling_forward_max
   import pool_pkg::*;
#(
   parameter int unsigned K_W    = 3,
   parameter int unsigned K_H    = 3,
   parameter int unsigned K_SIZE = K_W * K_H
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [K_SIZE-1:0][FLT_W-1:0] data_vect_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [FLT_W-1:0]             max_flt,
   output logic [IDX_W-1:0]             max_flt_idx,
   output logic                         nan_flag
);

   localparam int unsigned CNT_W = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_SIZE - 1);

   pool_fwd_state_t             state_q, state_d;
   logic [K_SIZE-1:0][FLT_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [FLT_W-1:0]            max_q, max_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic                        in_ready_q, in_ready_d;
   logic                        out_valid_q, out_valid_d;

   logic [FLT_W-1:0] cur_elem;
   logic             cur_gt;
   logic             accept;
   logic             upd;

   assign cur_elem = data_q[cnt_q];
   assign accept   = in_valid && in_ready_q;

   float_gt_cmp u_cmp (
      .a  (cur_elem),
      .b  (max_q),
      .gt (cur_gt)
   );

   // A NaN held from element 0 is displaced by the first non-NaN element.
   assign upd = cur_gt || (is_nan(max_q) && !is_nan(cur_elem));

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d  = data_vect_in;
               max_d   = data_vect_in[0];
               idx_d   = '0;
               cnt_d   = CNT_W'(1);
               state_d = (K_SIZE > 1) ? SCAN : DONE;
            end
         end
         SCAN: begin
            if (upd) begin
               max_d = cur_elem;
               idx_d = IDX_W'(cnt_q);
            end
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // Single-element windows enter DONE straight from IDLE, so
            // out_valid rises one edge later here.
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         cnt_q       <= '0;
         max_q       <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign max_flt     = max_q;
   assign max_flt_idx = idx_q;

`ifdef POOL_FWD_NAN_FLAG_EN
   logic nan_flag_q, nan_flag_d;

   // Accumulated as the scan visits each element; restarts on acceptance.
   always_comb begin
      nan_flag_d = nan_flag_q;
      if (state_q == IDLE && accept) begin
         nan_flag_d = is_nan(data_vect_in[0]);
      end else if (state_q == SCAN) begin
         nan_flag_d = nan_flag_q | is_nan(cur_elem);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nan_flag_q <= 1'b0;
      end else begin
         nan_flag_q <= nan_flag_d;
      end
   end

   assign nan_flag = nan_flag_q;
`else
   assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pooling_forward_max.sv
module tb_pooling_forward_max;
   import pool_pkg::*;

   localparam int K = 9;

   logic                    clk;
   logic                    reset_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [K-1:0][FLT_W-1:0] data_vect_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [FLT_W-1:0]        max_flt;
   logic [IDX_W-1:0]        max_flt_idx;
   logic                    nan_flag;

   int checks   = 0;
   int failures = 0;

`ifdef POOL_FWD_NAN_FLAG_EN
   localparam logic NAN_EXP = 1'b1;
`else
   localparam logic NAN_EXP = 1'b0;
`endif

   pooling_forward_max #(.K_W(3), .K_H(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_vect_in (data_vect_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .max_flt      (max_flt),
      .max_flt_idx  (max_flt_idx),
      .nan_flag     (nan_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a window, wait for acceptance, then count edges to out_valid.
   task automatic run_window(input logic [K-1:0][FLT_W-1:0] v, input string tag,
                             output int lat);
      int guard;
      data_vect_in = v;
      in_valid     = 1'b1;
      guard        = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      chk({tag, "_ready_seen"}, {31'd0, in_ready}, 32'd1);
      tick();                                 // acceptance edge
      in_valid     = 1'b0;
      data_vect_in = '1;                      // later changes must be ignored
      chk({tag, "_ready_drop"}, {31'd0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rdy_high"}, {31'd0, in_ready}, 32'd1);
   endtask

   logic [K-1:0][FLT_W-1:0] v;
   int lat;

   initial begin
      reset_n      = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      data_vect_in = '0;
      #12;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_max",       max_flt,            32'd0);
      chk("rst_idx",       {24'd0, max_flt_idx}, 32'd0);
      chk("rst_nan",       {31'd0, nan_flag},  32'd0);
      tick();
      reset_n = 1'b1;
      chk("post_rel_rdy", {31'd0, in_ready}, 32'd0);
      tick();
      chk("first_edge_rdy", {31'd0, in_ready}, 32'd1);

      // 1.0 everywhere, 2.0 at index 5
      for (int i = 0; i < K; i++) v[i] = 32'h3F800000;
      v[5] = 32'h40000000;
      run_window(v, "t1", lat);
      chk("t1_lat", lat, 32'd8);
      chk("t1_max", max_flt, 32'h40000000);
      chk("t1_idx", {24'd0, max_flt_idx}, 32'd5);
      chk("t1_nan", {31'd0, nan_flag}, 32'd0);
      handshake("t1");

      // all -3.0: tie keeps index 0
      for (int i = 0; i < K; i++) v[i] = 32'hC0400000;
      run_window(v, "t2", lat);
      chk("t2_max", max_flt, 32'hC0400000);
      chk("t2_idx", {24'd0, max_flt_idx}, 32'd0);
      handshake("t2");

      // NaN at 0, -2.0 elsewhere, -1.0 at 7
      for (int i = 0; i < K; i++) v[i] = 32'hC0000000;
      v[0] = 32'h7FC00000;
      v[7] = 32'hBF800000;
      run_window(v, "t3", lat);
      chk("t3_max", max_flt, 32'hBF800000);
      chk("t3_idx", {24'd0, max_flt_idx}, 32'd7);
      chk("t3_nan", {31'd0, nan_flag}, {31'd0, NAN_EXP});
      handshake("t3");

      // -0 at 1, +0 at 2, negatives elsewhere
      for (int i = 0; i < K; i++) v[i] = 32'hC0000000;
      v[1] = 32'h80000000;
      v[2] = 32'h00000000;
      run_window(v, "t4", lat);
      chk("t4_max", max_flt, 32'h80000000);
      chk("t4_idx", {24'd0, max_flt_idx}, 32'd1);
      chk("t4_nan", {31'd0, nan_flag}, 32'd0);

      // DONE held for 5 cycles with input noise
      for (int c = 0; c < 5; c++) begin
         data_vect_in = {K{32'h7F000000 + c}};
         in_valid     = c[0];
         tick();
         chk("t5_hold_ov",  {31'd0, out_valid}, 32'd1);
         chk("t5_hold_rdy", {31'd0, in_ready},  32'd0);
         chk("t5_hold_max", max_flt, 32'h80000000);
         chk("t5_hold_idx", {24'd0, max_flt_idx}, 32'd1);
      end
      in_valid = 1'b0;
      handshake("t5");
      // next window accepted at the very next edge
      for (int i = 0; i < K; i++) v[i] = 32'h3F000000 + i;
      run_window(v, "t5n", lat);
      chk("t5n_lat", lat, 32'd8);
      chk("t5n_max", max_flt, 32'h3F000008);
      chk("t5n_idx", {24'd0, max_flt_idx}, 32'd8);
      handshake("t5n");

      // reset during SCAN at cnt=4
      for (int i = 0; i < K; i++) v[i] = 32'h41000000;
      data_vect_in = v;
      in_valid     = 1'b1;
      tick();                                 // acceptance edge
      in_valid = 1'b0;
      tick(); tick(); tick();                 // cnt now 4
      reset_n = 1'b0;
      #1;
      chk("t6_rst_ov",  {31'd0, out_valid}, 32'd0);
      chk("t6_rst_rdy", {31'd0, in_ready},  32'd0);
      chk("t6_rst_max", max_flt, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("t6_rel_rdy", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < K; i++) v[i] = 32'hBF800000;
      v[3] = 32'h3F800000;
      run_window(v, "t6n", lat);
      chk("t6n_lat", lat, 32'd8);
      chk("t6n_max", max_flt, 32'h3F800000);
      chk("t6n_idx", {24'd0, max_flt_idx}, 32'd3);
      handshake("t6n");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
